// File: rtl/nn_loader_pkg.sv
// Shared types and command codes for the neural-network stream loader.
package nn_loader_pkg;

   typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_X, DONE} loader_state_t;

   localparam int unsigned CMD_LOAD_W = 1;
   localparam int unsigned CMD_LOAD_X = 2;

endpackage

// File: rtl/nn_addr_counter.sv
// Cascaded layer/row/column wrap counters; k fastest, then j, then layer.
// In j_only mode every increment steps j directly and k/layer stay put.
module nn_addr_counter #(
   parameter int unsigned LAYER_SIZE  = 4,
   parameter int unsigned LAYER_DEPTH = 4,
   localparam int unsigned LW = $clog2(LAYER_DEPTH),
   localparam int unsigned NW = $clog2(LAYER_SIZE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic          j_only,
   output logic [LW-1:0] layer,
   output logic [NW-1:0] node_j,
   output logic [NW-1:0] node_k,
   output logic          last,
   output logic          j_last
);

   localparam logic [NW-1:0] NodeMax  = NW'(LAYER_SIZE - 1);
   localparam logic [LW-1:0] LayerMax = LW'(LAYER_DEPTH - 1);

   logic [LW-1:0] layer_q, layer_d;
   logic [NW-1:0] j_q, j_d;
   logic [NW-1:0] k_q, k_d;
   logic          k_last, l_last;

   assign k_last = (k_q == NodeMax);
   assign j_last = (j_q == NodeMax);
   assign l_last = (layer_q == LayerMax);
   assign last   = k_last && j_last && l_last;

   always_comb begin
      layer_d = layer_q;
      j_d     = j_q;
      k_d     = k_q;
      if (clr) begin
         layer_d = '0;
         j_d     = '0;
         k_d     = '0;
      end else if (inc) begin
         if (j_only) begin
            j_d = j_last ? '0 : j_q + 1'b1;
         end else begin
            k_d = k_last ? '0 : k_q + 1'b1;
            if (k_last) begin
               j_d = j_last ? '0 : j_q + 1'b1;
               if (j_last) begin
                  layer_d = l_last ? '0 : layer_q + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         layer_q <= '0;
         j_q     <= '0;
         k_q     <= '0;
      end else begin
         layer_q <= layer_d;
         j_q     <= j_d;
         k_q     <= k_d;
      end
   end

   assign layer  = layer_q;
   assign node_j = j_q;
   assign node_k = k_q;

endmodule

// File: rtl/nn_stream_loader.sv
// Decodes a valid/ready command stream into write bursts on the network's
// weight or input memory port, generating layer/row/column addresses itself.
module nn_stream_loader
   import nn_loader_pkg::*;
#(
   parameter int unsigned LAYER_SIZE  = 4,
   parameter int unsigned LAYER_DEPTH = 4,
   parameter int unsigned BIT_SIZE    = 16,
   localparam int unsigned LW = $clog2(LAYER_DEPTH),
   localparam int unsigned NW = $clog2(LAYER_SIZE)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BIT_SIZE-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                abort,
   output logic                weight_write_enable,
   output logic                input_write_enable,
   output logic [LW-1:0]       addr_layer,
   output logic [NW-1:0]       addr_node_j,
   output logic [NW-1:0]       addr_node_k,
   output logic [BIT_SIZE-1:0] data_out,
   output logic                busy,
   output logic                done,
   output logic                cmd_err
);

   loader_state_t state_q, state_d;

   logic                wwe_q, wwe_d, iwe_q, iwe_d;
   logic [LW-1:0]       layer_q, layer_d;
   logic [NW-1:0]       j_q, j_d, k_q, k_d;
   logic [BIT_SIZE-1:0] data_q, data_d;
   logic                done_q, done_d, err_q, err_d;

   logic                accept, cnt_clr, cnt_inc, cnt_last, cnt_j_last;
   logic [LW-1:0]       cnt_layer;
   logic [NW-1:0]       cnt_j, cnt_k;

   // Not ready while reset is held, even though the state already reads IDLE.
   assign s_ready = rst && (state_q != DONE);
   assign accept  = s_valid && s_ready;
   assign busy    = (state_q == LOAD_W) || (state_q == LOAD_X);

   nn_addr_counter #(
      .LAYER_SIZE  (LAYER_SIZE),
      .LAYER_DEPTH (LAYER_DEPTH)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .j_only (state_q == LOAD_X),
      .layer  (cnt_layer),
      .node_j (cnt_j),
      .node_k (cnt_k),
      .last   (cnt_last),
      .j_last (cnt_j_last)
   );

   always_comb begin
      state_d = state_q;
      wwe_d   = 1'b0;
      iwe_d   = 1'b0;
      layer_d = layer_q;
      j_d     = j_q;
      k_d     = k_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (s_data == BIT_SIZE'(CMD_LOAD_W)) begin
                  state_d = LOAD_W;
                  cnt_clr = 1'b1;
               end else if (s_data == BIT_SIZE'(CMD_LOAD_X)) begin
                  state_d = LOAD_X;
                  cnt_clr = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD_W: begin
            if (abort) begin
               state_d = IDLE;
            end else if (accept) begin
               wwe_d   = 1'b1;
               layer_d = cnt_layer;
               j_d     = cnt_j;
               k_d     = cnt_k;
               data_d  = s_data;
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         LOAD_X: begin
            if (abort) begin
               state_d = IDLE;
            end else if (accept) begin
               iwe_d   = 1'b1;
               layer_d = '0;
               j_d     = cnt_j;
               k_d     = '0;
               data_d  = s_data;
               cnt_inc = 1'b1;
               if (cnt_j_last) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wwe_q   <= 1'b0;
         iwe_q   <= 1'b0;
         layer_q <= '0;
         j_q     <= '0;
         k_q     <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wwe_q   <= wwe_d;
         iwe_q   <= iwe_d;
         layer_q <= layer_d;
         j_q     <= j_d;
         k_q     <= k_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign weight_write_enable = wwe_q;
   assign input_write_enable  = iwe_q;
   assign addr_layer          = layer_q;
   assign addr_node_j         = j_q;
   assign addr_node_k         = k_q;
   assign data_out            = data_q;
   assign done                = done_q;
   assign cmd_err             = err_q;

endmodule

// File: tb/tb_nn_stream_loader.sv
// Scoreboard bench: instance 0 is 4x4x16, instance 1 is the 3-node, 2-layer
// variant; a reference model pushes expected events, monitors pop and compare.
module tb_nn_stream_loader;

   typedef struct {
      int kind;  // 0 weight write, 1 input write, 2 done, 3 cmd_err
      int l;
      int j;
      int k;
      int d;
   } evt_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] sd [2];
   logic        sv [2];
   logic        ab [2];
   logic        rdy[2];

   logic        wwe0, iwe0, busy0, done0, err0;
   logic [1:0]  al0, aj0, ak0;
   logic [15:0] do0;
   logic        wwe1, iwe1, busy1, done1, err1;
   logic [0:0]  al1;
   logic [1:0]  aj1, ak1;
   logic [15:0] do1;

   nn_stream_loader #(.LAYER_SIZE(4), .LAYER_DEPTH(4), .BIT_SIZE(16)) dut0 (
      .clk (clk), .rst (rst), .s_data (sd[0]), .s_valid (sv[0]), .s_ready (rdy[0]),
      .abort (ab[0]), .weight_write_enable (wwe0), .input_write_enable (iwe0),
      .addr_layer (al0), .addr_node_j (aj0), .addr_node_k (ak0), .data_out (do0),
      .busy (busy0), .done (done0), .cmd_err (err0)
   );

   nn_stream_loader #(.LAYER_SIZE(3), .LAYER_DEPTH(2), .BIT_SIZE(16)) dut1 (
      .clk (clk), .rst (rst), .s_data (sd[1]), .s_valid (sv[1]), .s_ready (rdy[1]),
      .abort (ab[1]), .weight_write_enable (wwe1), .input_write_enable (iwe1),
      .addr_layer (al1), .addr_node_j (aj1), .addr_node_k (ak1), .data_out (do1),
      .busy (busy1), .done (done1), .cmd_err (err1)
   );

   int   ncmp  = 0;
   int   nfail = 0;
   evt_t q[2][$];
   int   ms[2];
   int   idx[2];
   int   sz[2]  = '{4, 3};
   int   dep[2] = '{4, 2};

   task automatic cmpv(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk(input int inst, input int kind, input int l, input int j,
                      input int k, input int d);
      evt_t e;
      ncmp++;
      if (q[inst].size() == 0) begin
         nfail++;
         $display("FAIL unexpected_evt inst%0d: got kind %0d (%0d,%0d,%0d) d=%h, expected none",
                  inst, kind, l, j, k, d);
         return;
      end
      e = q[inst].pop_front();
      if (e.kind != kind || (kind < 2 && (e.l != l || e.j != j || e.k != k || e.d != d))) begin
         nfail++;
         $display("FAIL evt inst%0d: got kind %0d (%0d,%0d,%0d) d=%h, expected kind %0d (%0d,%0d,%0d) d=%h",
                  inst, kind, l, j, k, d, e.kind, e.l, e.j, e.k, e.d);
      end
   endtask

   always @(negedge clk) if (rst) begin
      if (wwe0) chk(0, 0, int'(al0), int'(aj0), int'(ak0), int'(do0));
      if (iwe0) chk(0, 1, int'(al0), int'(aj0), int'(ak0), int'(do0));
      if (done0) begin
         chk(0, 2, 0, 0, 0, 0);
         cmpv("s_ready_in_done0", int'(rdy[0]), 0);
      end
      if (err0) chk(0, 3, 0, 0, 0, 0);
   end

   always @(negedge clk) if (rst) begin
      if (wwe1) chk(1, 0, int'(al1), int'(aj1), int'(ak1), int'(do1));
      if (iwe1) chk(1, 1, int'(al1), int'(aj1), int'(ak1), int'(do1));
      if (done1) begin
         chk(1, 2, 0, 0, 0, 0);
         cmpv("s_ready_in_done1", int'(rdy[1]), 0);
      end
      if (err1) chk(1, 3, 0, 0, 0, 0);
   end

   function automatic evt_t mk(input int kind, input int l, input int j, input int k,
                               input int d);
      evt_t e;
      e.kind = kind; e.l = l; e.j = j; e.k = k; e.d = d;
      return e;
   endfunction

   // Reference: burst position n maps to (n / S^2, (n / S) % S, n % S).
   task automatic model(input int inst, input int w, input bit a);
      int s = sz[inst];
      case (ms[inst])
         0: begin
            if (w == 1) begin ms[inst] = 1; idx[inst] = 0; end
            else if (w == 2) begin ms[inst] = 2; idx[inst] = 0; end
            else q[inst].push_back(mk(3, 0, 0, 0, 0));
         end
         1: begin
            if (a) ms[inst] = 0;
            else begin
               q[inst].push_back(mk(0, idx[inst] / (s * s), (idx[inst] / s) % s,
                                    idx[inst] % s, w));
               idx[inst]++;
               if (idx[inst] == dep[inst] * s * s) begin
                  q[inst].push_back(mk(2, 0, 0, 0, 0));
                  ms[inst] = 0;
               end
            end
         end
         default: begin
            if (a) ms[inst] = 0;
            else begin
               q[inst].push_back(mk(1, 0, idx[inst], 0, w));
               idx[inst]++;
               if (idx[inst] == s) begin
                  q[inst].push_back(mk(2, 0, 0, 0, 0));
                  ms[inst] = 0;
               end
            end
         end
      endcase
   endtask

   // Called at posedge+1; holds the word until the DUT takes it (bounded).
   task automatic send(input int inst, input int w, input bit a);
      sd[inst] = 16'(w);
      sv[inst] = 1'b1;
      ab[inst] = a;
      for (int n = 0; n < 50; n++) begin
         if (rdy[inst]) begin
            @(posedge clk); #1;
            model(inst, w, a);
            sv[inst] = 1'b0;
            ab[inst] = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      ncmp++;
      nfail++;
      $display("FAIL send_timeout inst%0d: s_ready stayed 0, expected 1", inst);
      sv[inst] = 1'b0;
      ab[inst] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int r, cmd, inst, n, abort_at;
      for (int i = 0; i < 2; i++) begin
         sd[i] = '0; sv[i] = 1'b0; ab[i] = 1'b0; ms[i] = 0; idx[i] = 0;
      end
      #12;
      cmpv("reset_s_ready", int'(rdy[0]), 0);
      cmpv("reset_busy", int'(busy0), 0);
      cmpv("reset_wwe", int'(wwe0), 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Full weight load, back-to-back.
      send(0, 1, 0);
      for (int i = 0; i < 64; i++) send(0, 16'h100 + i, 0);
      cmpv("busy_after_wload", int'(busy0), 0);
      idle(1);

      // Input load with gaps.
      send(0, 2, 0);
      for (int i = 0; i < 4; i++) begin
         send(0, 16'hA0 + i, 0);
         idle(1 + i % 2);
      end

      // Bad command, then a normal input load.
      send(0, 16'h0007, 0);
      cmpv("busy_after_badcmd", int'(busy0), 0);
      send(0, 2, 0);
      for (int i = 0; i < 4; i++) send(0, 16'hB0 + i, 0);
      idle(1);

      // Abort with word 11; restart must begin at (0,0,0).
      send(0, 1, 0);
      for (int i = 0; i < 10; i++) send(0, 16'hC0 + i, 0);
      send(0, 16'hCA, 1);
      cmpv("busy_after_abort", int'(busy0), 0);
      send(0, 1, 0);
      send(0, 16'hD00, 0);
      send(0, 16'hD01, 1);

      // Non-power-of-two instance: 18 weights, then an input load.
      send(1, 1, 0);
      for (int i = 0; i < 18; i++) send(1, 16'h200 + i, 0);
      send(1, 2, 0);
      for (int i = 0; i < 3; i++) send(1, 16'h300 + i, 0);
      idle(1);

      // Reset mid-burst.
      send(0, 1, 0);
      for (int i = 0; i < 5; i++) send(0, 16'hE0 + i, 0);
      rst = 1'b0;
      #1;
      cmpv("rst_wwe", int'(wwe0), 0);
      cmpv("rst_addr_k", int'(ak0), 0);
      cmpv("rst_data", int'(do0), 0);
      cmpv("rst_busy", int'(busy0), 0);
      cmpv("rst_s_ready", int'(rdy[0]), 0);
      q[0].delete(); q[1].delete();
      ms[0] = 0; ms[1] = 0;
      #10;
      rst = 1'b1;
      @(posedge clk); #1;
      send(0, 2, 0);
      for (int i = 0; i < 4; i++) send(0, 16'hF0 + i, 0);

      // Randomized bursts on both instances.
      repeat (14) begin
         r    = $urandom_range(0, 9);
         cmd  = (r < 4) ? 1 : (r < 8) ? 2 : ((r == 8) ? 0 : $urandom_range(3, 65535));
         inst = $urandom_range(0, 1);
         send(inst, cmd, 0);
         if (cmd == 1 || cmd == 2) begin
            n        = (cmd == 1) ? dep[inst] * sz[inst] * sz[inst] : sz[inst];
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            for (int i = 0; i < n; i++) begin
               if (i == abort_at) begin
                  send(inst, $urandom_range(0, 65535), 1);
                  break;
               end
               send(inst, $urandom_range(0, 65535), 0);
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
         end
         idle(2);
      end

      idle(4);
      cmpv("queue0_drained", q[0].size(), 0);
      cmpv("queue1_drained", q[1].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
